// File: rtl/axil_lite_master.sv
// AXI-lite initiator: single-beat register commands in, AXI-lite transactions out,
// one transaction outstanding, with a per-state wait-cycle timeout for hung responders.

package axi_pkg;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic                    awvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wvalid;
        logic                    bready;
        logic [AXI_ADDR_W-1:0]   araddr;
        logic                    arvalid;
        logic                    rready;
    } axi_lite_mosi;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rvalid;
    } axi_lite_miso;
endpackage

module axil_lite_master
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output axi_lite_mosi        axio_o,
    input  axi_lite_miso        axii_i
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WRESP, S_READ_A, S_READ_D, S_RSP
    } state_t;

    state_t r_state, w_state_nxt;

    logic                r_cmd_ready,   w_cmd_ready;
    logic [ADDR_W-1:0]   r_awaddr,      w_awaddr;
    logic                r_awvalid,     w_awvalid;
    logic [DATA_W-1:0]   r_wdata,       w_wdata;
    logic [DATA_W/8-1:0] r_wstrb,       w_wstrb;
    logic                r_wvalid,      w_wvalid;
    logic                r_bready,      w_bready;
    logic [ADDR_W-1:0]   r_araddr,      w_araddr;
    logic                r_arvalid,     w_arvalid;
    logic                r_rready,      w_rready;
    logic                r_rsp_valid,   w_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata,   w_rsp_rdata;
    logic [1:0]          r_rsp_resp,    w_rsp_resp;
    logic                r_rsp_timeout, w_rsp_timeout;
    logic [TCNT_W-1:0]   r_tcnt,        w_tcnt;
    logic                w_busy, w_to_hit;

    // State and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_awaddr      <= '0;
            r_awvalid     <= 1'b0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
            r_tcnt        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready;
            r_awaddr      <= w_awaddr;
            r_awvalid     <= w_awvalid;
            r_wdata       <= w_wdata;
            r_wstrb       <= w_wstrb;
            r_wvalid      <= w_wvalid;
            r_bready      <= w_bready;
            r_araddr      <= w_araddr;
            r_arvalid     <= w_arvalid;
            r_rready      <= w_rready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_resp    <= w_rsp_resp;
            r_rsp_timeout <= w_rsp_timeout;
            r_tcnt        <= w_tcnt;
        end
    end

    // Next-state and next-output values; timeout overrides any partial progress
    always_comb begin
        w_state_nxt   = r_state;
        w_awaddr      = r_awaddr;
        w_awvalid     = r_awvalid;
        w_wdata       = r_wdata;
        w_wstrb       = r_wstrb;
        w_wvalid      = r_wvalid;
        w_bready      = r_bready;
        w_araddr      = r_araddr;
        w_arvalid     = r_arvalid;
        w_rready      = r_rready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_resp    = r_rsp_resp;
        w_rsp_timeout = r_rsp_timeout;
        w_busy   = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                   (r_state == S_READ_A) || (r_state == S_READ_D);
        w_to_hit = (TIMEOUT_CYCLES != 0) &&
                   ((32'(r_tcnt) + 32'd1) == 32'(TIMEOUT_CYCLES));

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    if (cmd_write) begin
                        w_awaddr    = cmd_addr;
                        w_wdata     = cmd_wdata;
                        w_wstrb     = cmd_wstrb;
                        w_awvalid   = 1'b1;
                        w_wvalid    = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_araddr    = cmd_addr;
                        w_arvalid   = 1'b1;
                        w_state_nxt = S_READ_A;
                    end
                end
            end
            S_WRITE: begin
                // Each valid still pending is its registered value minus this cycle's ready
                w_awvalid = r_awvalid && !axii_i.awready;
                w_wvalid  = r_wvalid && !axii_i.wready;
                if (!w_awvalid && !w_wvalid) begin
                    w_bready    = 1'b1;
                    w_state_nxt = S_WRESP;
                end
            end
            S_WRESP: begin
                if (axii_i.bvalid) begin
                    w_bready      = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_rdata   = '0;
                    w_rsp_resp    = axii_i.bresp;
                    w_rsp_timeout = 1'b0;
                    w_state_nxt   = S_RSP;
                end
            end
            S_READ_A: begin
                if (axii_i.arready) begin
                    w_arvalid   = 1'b0;
                    w_rready    = 1'b1;
                    w_state_nxt = S_READ_D;
                end
            end
            S_READ_D: begin
                if (axii_i.rvalid) begin
                    w_rready      = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_rdata   = DATA_W'(axii_i.rdata);
                    w_rsp_resp    = axii_i.rresp;
                    w_rsp_timeout = 1'b0;
                    w_state_nxt   = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Timeout only fires when this cycle did not complete the state's handshake
        if (w_busy && (w_state_nxt == r_state) && w_to_hit) begin
            w_awvalid     = 1'b0;
            w_wvalid      = 1'b0;
            w_bready      = 1'b0;
            w_arvalid     = 1'b0;
            w_rready      = 1'b0;
            w_rsp_valid   = 1'b1;
            w_rsp_rdata   = '0;
            w_rsp_resp    = 2'h3;
            w_rsp_timeout = 1'b1;
            w_state_nxt   = S_RSP;
        end

        w_cmd_ready = (w_state_nxt == S_IDLE);

        if (w_state_nxt != r_state)
            w_tcnt = '0;
        else if (w_busy && (r_tcnt != '1))
            w_tcnt = r_tcnt + 1'b1;
        else
            w_tcnt = r_tcnt;
    end

    // Pack registered channel signals onto the AXI-lite struct
    always_comb begin
        axio_o         = '0;
        axio_o.awaddr  = AXI_ADDR_W'(r_awaddr);
        axio_o.awvalid = r_awvalid;
        axio_o.wdata   = AXI_DATA_W'(r_wdata);
        axio_o.wstrb   = (AXI_DATA_W/8)'(r_wstrb);
        axio_o.wvalid  = r_wvalid;
        axio_o.bready  = r_bready;
        axio_o.araddr  = AXI_ADDR_W'(r_araddr);
        axio_o.arvalid = r_arvalid;
        axio_o.rready  = r_rready;
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_axil_lite_master.sv
// Directed bench for axil_lite_master with a behavioural AXI-lite register responder.
module tb_axil_lite_master;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_ready, rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    axi_lite_mosi mosi;
    axi_lite_miso miso;

    int total = 0;
    int bad = 0;

    axil_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .axio_o(mosi), .axii_i(miso)
    );

    always #5 clk = ~clk;

    // ---------------- responder model ----------------
    logic [31:0] mem [0:15];
    logic        have_aw, have_w, have_ar;
    logic [31:0] wa, wd, ra;
    logic [3:0]  ws;
    int          aw_wait, w_wait;
    int          aw_delay = 0, w_delay = 0;
    logic        ar_never = 1'b0, r_hold = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
        return m;
    endfunction

    always_comb begin
        miso         = '0;
        miso.awready = mosi.awvalid && (aw_wait >= aw_delay) && !have_aw;
        miso.wready  = mosi.wvalid && (w_wait >= w_delay) && !have_w;
        miso.bvalid  = have_aw && have_w;
        miso.bresp   = 2'h0;
        miso.arready = mosi.arvalid && !ar_never && !have_ar;
        miso.rvalid  = have_ar && !r_hold;
        miso.rdata   = (ra < 32'h40) ? mem[ra[5:2]] : 32'hDEAD_0040;
        miso.rresp   = (ra < 32'h40) ? 2'h0 : 2'h3;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0;
            aw_wait <= 0; w_wait <= 0;
            wa <= '0; wd <= '0; ws <= '0; ra <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= (i == 1) ? 32'h2904_2023 : 32'h0;
        end else begin
            aw_wait <= (mosi.awvalid && !miso.awready) ? aw_wait + 1 : 0;
            w_wait  <= (mosi.wvalid && !miso.wready) ? w_wait + 1 : 0;
            if (mosi.awvalid && miso.awready) begin have_aw <= 1'b1; wa <= mosi.awaddr; end
            if (mosi.wvalid && miso.wready) begin
                have_w <= 1'b1; wd <= mosi.wdata; ws <= mosi.wstrb;
            end
            if (miso.bvalid && mosi.bready) begin
                have_aw <= 1'b0; have_w <= 1'b0;
                if (wa < 32'h40) mem[wa[5:2]] <= merge(mem[wa[5:2]], wd, ws);
            end
            if (mosi.arvalid && miso.arready) begin have_ar <= 1'b1; ra <= mosi.araddr; end
            if (miso.rvalid && mosi.rready) have_ar <= 1'b0;
        end
    end

    // ---------------- transaction helpers ----------------
    int          res_lat, res_aw, res_w, res_ar;
    logic [31:0] res_rdata;
    logic [1:0]  res_resp;
    logic        res_tmo;
    logic        res_ok;

    // Issue one command and wait for rsp_valid; latency counts cycles after the accept cycle
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        int n;
        res_lat = 0; res_aw = 0; res_w = 0; res_ar = 0; res_ok = 1'b1;
        @(negedge clk);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            total++; bad++; res_ok = 1'b0;
            $display("FAIL accept_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        while (res_lat < 200) begin
            @(negedge clk); res_lat++;
            if (rsp_valid) break;
            if (mosi.awvalid) res_aw++;
            if (mosi.wvalid)  res_w++;
            if (mosi.arvalid) res_ar++;
        end
        if (!rsp_valid) begin
            total++; bad++; res_ok = 1'b0;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, res_lat);
        end
        res_rdata = rsp_rdata; res_resp = rsp_resp; res_tmo = rsp_timeout;
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (mosi !== '0) begin bad++; $display("FAIL reset_axio: got=%h required=0", mosi); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got=%b required=0", cmd_ready); end
        total++; if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== '0) begin
            bad++; $display("FAIL reset_rsp: got v=%b d=%h r=%h t=%b required all 0",
                            rsp_valid, rsp_rdata, rsp_resp, rsp_timeout);
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready: got=%b required=1", cmd_ready); end
    endtask

    task automatic test_read_min();
        send(1'b0, 32'h04, '0, '0);
        total++; if (res_rdata !== 32'h2904_2023) begin bad++; $display("FAIL read04_data: got=%h required=29042023", res_rdata); end
        total++; if (res_resp !== 2'h0 || res_tmo !== 1'b0) begin bad++; $display("FAIL read04_resp: got resp=%h tmo=%b required 0/0", res_resp, res_tmo); end
        total++; if (res_lat !== 3) begin bad++; $display("FAIL read04_latency: got=%0d required=3", res_lat); end
        take();
    endtask

    task automatic test_write_min();
        send(1'b1, 32'h0C, 32'h1234_5678, 4'hF);
        total++; if (res_lat !== 3) begin bad++; $display("FAIL write0c_latency: got=%0d required=3", res_lat); end
        total++; if (res_resp !== 2'h0 || res_rdata !== 32'h0) begin bad++; $display("FAIL write0c_rsp: got resp=%h data=%h required 0/0", res_resp, res_rdata); end
        take();
    endtask

    task automatic test_write_aw_first();
        aw_delay = 0; w_delay = 3;
        send(1'b1, 32'h08, 32'hA5A5_0F0F, 4'hF);
        total++; if (res_aw !== 1 || res_w !== 4) begin bad++; $display("FAIL awfirst_valid_cycles: got aw=%0d w=%0d required aw=1 w=4", res_aw, res_w); end
        total++; if (res_lat !== 6) begin bad++; $display("FAIL awfirst_latency: got=%0d required=6", res_lat); end
        total++; if (res_resp !== 2'h0 || res_tmo !== 1'b0) begin bad++; $display("FAIL awfirst_bresp: got resp=%h tmo=%b required 0/0", res_resp, res_tmo); end
        take();
        w_delay = 0;
        send(1'b0, 32'h08, '0, '0);
        total++; if (res_rdata !== 32'hA5A5_0F0F) begin bad++; $display("FAIL readback08: got=%h required=a5a50f0f", res_rdata); end
        take();
    endtask

    task automatic test_write_w_first();
        aw_delay = 2; w_delay = 0;
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
        total++; if (res_aw !== 3 || res_w !== 1) begin bad++; $display("FAIL wfirst_valid_cycles: got aw=%0d w=%0d required aw=3 w=1", res_aw, res_w); end
        take();
        aw_delay = 0;
        send(1'b0, 32'h10, '0, '0);
        total++; if (res_rdata !== 32'h0000_BEEF) begin bad++; $display("FAIL readback10_strb: got=%h required=0000beef", res_rdata); end
        take();
    endtask

    task automatic test_unmapped();
        send(1'b0, 32'h40, '0, '0);
        total++; if (res_resp !== 2'h3 || res_tmo !== 1'b0) begin bad++; $display("FAIL unmapped_resp: got resp=%h tmo=%b required 3/0", res_resp, res_tmo); end
        total++; if (res_rdata !== 32'hDEAD_0040) begin bad++; $display("FAIL unmapped_data: got=%h required=dead0040", res_rdata); end
        take();
    endtask

    task automatic test_timeout();
        ar_never = 1'b1;
        send(1'b0, 32'h04, '0, '0);
        total++; if (res_ar !== 16) begin bad++; $display("FAIL timeout_arvalid_cycles: got=%0d required=16", res_ar); end
        total++; if (res_lat !== 17) begin bad++; $display("FAIL timeout_latency: got=%0d required=17", res_lat); end
        total++; if (res_resp !== 2'h3 || res_tmo !== 1'b1 || res_rdata !== 32'h0) begin
            bad++; $display("FAIL timeout_rsp: got resp=%h tmo=%b data=%h required 3/1/0", res_resp, res_tmo, res_rdata);
        end
        total++; if (mosi.arvalid !== 1'b0) begin bad++; $display("FAIL timeout_arvalid_drop: got=%b required=0", mosi.arvalid); end
        take();
        ar_never = 1'b0;
        send(1'b0, 32'h04, '0, '0);
        total++; if (res_rdata !== 32'h2904_2023 || res_tmo !== 1'b0 || res_lat !== 3) begin
            bad++; $display("FAIL after_timeout_read: got data=%h tmo=%b lat=%0d required 29042023/0/3", res_rdata, res_tmo, res_lat);
        end
        take();
    endtask

    task automatic test_stall();
        send(1'b0, 32'h04, '0, '0);
        cmd_write = 1'b1; cmd_addr = 32'h0C; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2904_2023 || rsp_resp !== 2'h0 || rsp_timeout !== 1'b0) begin
                bad++; $display("FAIL stall_rsp_stable[%0d]: got v=%b d=%h r=%h t=%b required 1/29042023/0/0",
                                c, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout);
            end
            total++; if (cmd_ready !== 1'b0 || mosi.awvalid !== 1'b0 || mosi.arvalid !== 1'b0) begin
                bad++; $display("FAIL stall_no_accept[%0d]: got cmd_ready=%b awvalid=%b arvalid=%b required 0/0/0",
                                c, cmd_ready, mosi.awvalid, mosi.arvalid);
            end
        end
        cmd_valid = 1'b0;
        take();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL stall_release: got rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        r_hold = 1'b1;
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 32'h04; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!mosi.rready && n < 20);
        total++; if (mosi.rready !== 1'b1) begin bad++; $display("FAIL reach_read_d: rready=%b required=1", mosi.rready); end
        rst = 1'b1;
        #1;
        total++; if ({mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready} !== 5'b0) begin
            bad++; $display("FAIL reset_drop_valids: got=%b required=00000",
                            {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready});
        end
        @(negedge clk);
        rst = 1'b0; r_hold = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL no_rsp_after_reset[%0d]: got=%b required=0", c, rsp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_read_min();
        test_write_min();
        test_write_aw_first();
        test_write_w_first();
        test_unmapped();
        test_timeout();
        test_stall();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
